// File: rtl/ghash_pkg.sv
// Shared types and constants for the GHASH engine: FSM states, block kinds,
// block width, GCM reduction polynomial and the byte-granular pad helper.
package ghash_pkg;

    localparam int WIDTH = 128;
    localparam logic [127:0] GCM_R = {8'he1, 120'd0};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABSORB,
        ST_MUL,
        ST_LEN,
        ST_MUL_LEN,
        ST_DONE
    } state_t;

    typedef enum logic {
        BLK_AAD = 1'b0,
        BLK_CT  = 1'b1
    } blk_t;

    // Keep the first n bytes (byte 0 = bits[127:120]), force the rest to zero.
    function automatic logic [127:0] pad_block(input logic [127:0] d, input logic [4:0] n);
        logic [127:0] m;
        m = '0;
        for (int k = 0; k < 16; k++) begin
            if (k < int'(n)) m[127-8*k -: 8] = 8'hff;
        end
        return d & m;
    endfunction

endpackage

// File: rtl/gf128_mul_serial.sv
// Digit-serial GF(2^128) multiplier, GCM bit-reflected; result valid with done on
// the last of 128/DIGIT cycles after load, no backpressure (load restarts it).
module gf128_mul_serial
    import ghash_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [127:0] a,
    input  logic [127:0] b,
    output logic         done,
    output logic [127:0] result
);

    localparam int NSTEP = WIDTH / DIGIT;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    logic [127:0]         z, v, x;
    logic [127:0]         z_nxt, v_nxt;
    logic [WIDTH+DIGIT-1:0] x_ext;
    logic [CW-1:0]        cnt;
    logic                 run;

    // DIGIT multiplier bits per cycle, consumed MSB-first (GCM bit 0 = bit 127).
    always_comb begin
        z_nxt = z;
        v_nxt = v;
        for (int i = 0; i < DIGIT; i++) begin
            if (x[WIDTH-1-i]) z_nxt = z_nxt ^ v_nxt;
            v_nxt = v_nxt[0] ? ((v_nxt >> 1) ^ GCM_R) : (v_nxt >> 1);
        end
    end

    assign x_ext  = {x, {DIGIT{1'b0}}};
    assign done   = run && (cnt == CW'(NSTEP - 1));
    assign result = z_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z   <= '0;
            v   <= '0;
            x   <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (load) begin
            z   <= '0;
            v   <= b;
            x   <= a;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            z   <= z_nxt;
            v   <= v_nxt;
            x   <= x_ext[WIDTH-1:0];
            cnt <= cnt + 1'b1;
            if (done) run <= 1'b0;
        end
    end

endmodule

// File: rtl/ghash_engine.sv
// GHASH over AAD/CT blocks plus length block; one block per 128/DIGIT+1 cycles,
// in_ready only in ABSORB, tag held in DONE until tag_ready.
module ghash_engine #(
    parameter int DIGIT = 8,
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] h_data,
    input  logic             h_load,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_type,
    input  logic [4:0]       in_bytes,
    input  logic             in_last,
    output logic             tag_valid,
    input  logic             tag_ready,
    output logic [WIDTH-1:0] tag,
    output logic             busy,
    output logic             err
);
    import ghash_pkg::*;

    if (WIDTH != ghash_pkg::WIDTH || DIGIT < 1 || DIGIT > 128 || (128 % DIGIT) != 0) begin : g_bad_param
        $error("ghash_engine: unsupported WIDTH/DIGIT");
    end

    state_t       state;
    blk_t         btype;
    logic [127:0] h_reg, s_reg;
    logic [63:0]  len_a, len_c, bits_add;
    logic         seen_ct, part_a, part_c, last_blk;
    logic         hs, blk_err, blk_abs;
    logic         mul_load, mul_done;
    logic [127:0] mul_a, mul_result;

    assign btype    = blk_t'(in_type);
    assign hs       = in_valid & in_ready;
    assign bits_add = {56'd0, in_bytes, 3'd0};

    // Ordering rules: AAD never after CT, and a short block must end its section.
    always_comb begin
        blk_err = 1'b0;
        if (in_bytes > 5'd16) begin
            blk_err = 1'b1;
        end else if (in_bytes != 5'd0) begin
            if (btype == BLK_AAD) blk_err = seen_ct | part_a;
            else                  blk_err = part_c;
        end
    end

    assign blk_abs  = hs & ~blk_err & (in_bytes != 5'd0);
    assign mul_load = blk_abs | (state == ST_LEN);
    assign mul_a    = (state == ST_LEN) ? (s_reg ^ {len_a, len_c})
                                        : (s_reg ^ pad_block(in_data, in_bytes));

    gf128_mul_serial #(.DIGIT(DIGIT)) u_mul (
        .clk    (clk),
        .rst    (rst),
        .load   (mul_load),
        .a      (mul_a),
        .b      (h_reg),
        .done   (mul_done),
        .result (mul_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            h_reg     <= '0;
            s_reg     <= '0;
            len_a     <= '0;
            len_c     <= '0;
            seen_ct   <= 1'b0;
            part_a    <= 1'b0;
            part_c    <= 1'b0;
            last_blk  <= 1'b0;
            in_ready  <= 1'b0;
            tag_valid <= 1'b0;
            tag       <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (h_load) h_reg <= h_data;
                    if (start) begin
                        state    <= ST_ABSORB;
                        s_reg    <= '0;
                        len_a    <= '0;
                        len_c    <= '0;
                        seen_ct  <= 1'b0;
                        part_a   <= 1'b0;
                        part_c   <= 1'b0;
                        err      <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_ABSORB: begin
                    if (hs) begin
                        if (blk_err) err <= 1'b1;
                        if (blk_abs) begin
                            state    <= ST_MUL;
                            in_ready <= 1'b0;
                            last_blk <= in_last;
                            if (btype == BLK_CT) begin
                                len_c   <= len_c + bits_add;
                                seen_ct <= 1'b1;
                                part_c  <= (in_bytes != 5'd16);
                            end else begin
                                len_a  <= len_a + bits_add;
                                part_a <= (in_bytes != 5'd16);
                            end
                        end else if (in_last) begin
                            state    <= ST_LEN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        s_reg <= mul_result;
                        if (last_blk) begin
                            state <= ST_LEN;
                        end else begin
                            state    <= ST_ABSORB;
                            in_ready <= 1'b1;
                        end
                    end
                end
                ST_LEN: state <= ST_MUL_LEN;
                ST_MUL_LEN: begin
                    if (mul_done) begin
                        s_reg     <= mul_result;
                        tag       <= mul_result;
                        tag_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (tag_ready) begin
                        tag_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ghash_engine.sv
// Three engines (DIGIT 1, 8, 128) fed identical messages; a monitor scores tags
// against an expected-tag queue and measures the in_ready gap after each block.
module tb_ghash_engine;

    localparam logic [127:0] H_KEY = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] C_BLK = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] T_C   = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] h_data, in_data;
    logic         h_load, start, in_type, in_last;
    logic [4:0]   in_bytes;
    logic [2:0]   in_valid, in_ready, tag_valid, tag_ready, busy, err;
    logic [127:0] tag_o [3];

    int           total = 0;
    int           bad   = 0;
    logic [127:0] exp_q [$];
    bit           gap_chk = 1'b0;
    int           idx [3] = '{0, 0, 0};
    int           gap [3] = '{0, 0, 0};
    bit           counting [3] = '{1'b0, 1'b0, 1'b0};
    int           nstep [3] = '{128, 16, 1};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ghash_engine #(.DIGIT((g == 0) ? 1 : (g == 1) ? 8 : 128), .WIDTH(128)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .h_data    (h_data),
            .h_load    (h_load),
            .start     (start),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data),
            .in_type   (in_type),
            .in_bytes  (in_bytes),
            .in_last   (in_last),
            .tag_valid (tag_valid[g]),
            .tag_ready (tag_ready[g]),
            .tag       (tag_o[g]),
            .busy      (busy[g]),
            .err       (err[g])
        );
    end

    function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z, v;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ {8'he1, 120'd0}) : (v >> 1);
        end
        return z;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out", nm);
    endtask

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (rst) counting[k] = 1'b0;
                if (counting[k]) begin
                    if (in_ready[k]) begin
                        chk($sformatf("in_ready_gap[%0d]", k), 128'(gap[k]), 128'(nstep[k]));
                        counting[k] = 1'b0;
                    end else if (gap[k] > 300) begin
                        timeout($sformatf("in_ready_gap[%0d]", k));
                        counting[k] = 1'b0;
                    end else begin
                        gap[k]++;
                    end
                end
                if (in_valid[k] && in_ready[k] && gap_chk) begin
                    counting[k] = 1'b1;
                    gap[k]      = 0;
                end
                if (tag_valid[k] && tag_ready[k]) begin
                    if (idx[k] < exp_q.size()) begin
                        chk($sformatf("tag[%0d]#%0d", k, idx[k]), tag_o[k], exp_q[idx[k]]);
                        idx[k]++;
                    end else begin
                        chk($sformatf("unexpected_tag_valid[%0d]", k), 128'(tag_valid[k]), 128'd0);
                    end
                end
            end
        end
    end

    task automatic start_msg();
        @(posedge clk); #1;
        h_data = H_KEY;
        h_load = 1'b1;
        start  = 1'b1;
        @(posedge clk); #1;
        h_load = 1'b0;
        start  = 1'b0;
        h_data = '0;
    endtask

    // Present one block to all engines; each drops its valid once it has accepted.
    task automatic send_block(input logic [127:0] d, input logic typ, input logic [4:0] nb,
                              input logic last, input bit gchk);
        logic [2:0] pend, hs;
        int t;
        pend = 3'b111;
        t    = 0;
        @(posedge clk); #1;
        in_data  = d;
        in_type  = typ;
        in_bytes = nb;
        in_last  = last;
        gap_chk  = gchk;
        in_valid = pend;
        hs       = pend & in_ready;
        while (pend != 3'b000 && t < 2000) begin
            @(posedge clk); #1;
            t++;
            pend     = pend & ~hs;
            in_valid = pend;
            hs       = pend & in_ready;
        end
        in_valid = 3'b000;
        if (pend != 3'b000) timeout("send_block");
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (t < 3000 && !(busy == 3'b000 && idx[0] == exp_q.size() &&
                             idx[1] == exp_q.size() && idx[2] == exp_q.size())) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 3000) timeout("wait_done");
    endtask

    task automatic chk_err(input logic e);
        for (int k = 0; k < 3; k++) chk($sformatf("err[%0d]", k), 128'(err[k]), 128'(e));
    endtask

    initial begin
        logic [127:0] s, a1, c1, aad_g, aad_z, c2_g, c2_z;
        int t;
        a1    = 128'h00112233445566778899aabbccddeeff;
        c1    = 128'hdeadbeef0123456789abcdef55aa33cc;
        aad_g = 128'hfeedfacede_112233445566778899aabb;
        aad_z = 128'hfeedfacede_0000000000_000000000000;
        c2_g  = 128'ha1a2a3a4a5a6a7_ffffffffffffffffff;
        c2_z  = 128'ha1a2a3a4a5a6a7_000000000000000000;

        rst = 1'b1; h_data = '0; h_load = 1'b0; start = 1'b0; in_valid = 3'b000;
        in_data = '0; in_type = 1'b0; in_bytes = '0; in_last = 1'b0; tag_ready = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_in_ready[%0d]", k), 128'(in_ready[k]), 128'd0);
            chk($sformatf("rst_tag_valid[%0d]", k), 128'(tag_valid[k]), 128'd0);
            chk($sformatf("rst_tag[%0d]", k), tag_o[k], 128'd0);
            chk($sformatf("rst_busy[%0d]", k), 128'(busy[k]), 128'd0);
            chk($sformatf("rst_err[%0d]", k), 128'(err[k]), 128'd0);
        end
        rst = 1'b0;

        // Empty message: lone terminator.
        exp_q.push_back(128'd0);
        start_msg();
        send_block('0, 1'b1, 5'd0, 1'b1, 1'b0);
        wait_done();
        chk_err(1'b0);

        // Single full CT block.
        exp_q.push_back(T_C);
        start_msg();
        send_block(C_BLK, 1'b1, 5'd16, 1'b1, 1'b0);
        wait_done();
        chk_err(1'b0);

        // 5-byte AAD with garbage beyond the valid bytes.
        exp_q.push_back(gf_mul(gf_mul(aad_z, H_KEY) ^ {64'd40, 64'd0}, H_KEY));
        start_msg();
        send_block(aad_g, 1'b0, 5'd5, 1'b0, 1'b1);
        send_block('0, 1'b0, 5'd0, 1'b1, 1'b0);
        wait_done();
        chk_err(1'b0);
        chk("len_a[0]", 128'(g_dut[0].u_dut.len_a), 128'd40);
        chk("len_a[1]", 128'(g_dut[1].u_dut.len_a), 128'd40);
        chk("len_a[2]", 128'(g_dut[2].u_dut.len_a), 128'd40);

        // AAD after CT is dropped.
        exp_q.push_back(T_C);
        start_msg();
        send_block(C_BLK, 1'b1, 5'd16, 1'b0, 1'b1);
        send_block(a1, 1'b0, 5'd16, 1'b0, 1'b0);
        send_block('0, 1'b1, 5'd0, 1'b1, 1'b0);
        wait_done();
        chk_err(1'b1);

        // Mixed message: full AAD, full CT, 7-byte CT tail.
        s = gf_mul(a1, H_KEY);
        s = gf_mul(s ^ c1, H_KEY);
        s = gf_mul(s ^ c2_z, H_KEY);
        s = gf_mul(s ^ {64'd128, 64'd184}, H_KEY);
        exp_q.push_back(s);
        start_msg();
        send_block(a1, 1'b0, 5'd16, 1'b0, 1'b1);
        send_block(c1, 1'b1, 5'd16, 1'b0, 1'b1);
        send_block(c2_g, 1'b1, 5'd7, 1'b1, 1'b0);
        wait_done();
        chk_err(1'b0);

        // Oversize block dropped.
        exp_q.push_back(T_C);
        start_msg();
        send_block(C_BLK, 1'b1, 5'd17, 1'b0, 1'b0);
        send_block(C_BLK, 1'b1, 5'd16, 1'b1, 1'b0);
        wait_done();
        chk_err(1'b1);

        // Partial CT followed by another CT: the last block is dropped, lengths kept.
        exp_q.push_back(gf_mul(gf_mul(c2_z, H_KEY) ^ {64'd0, 64'd56}, H_KEY));
        start_msg();
        send_block(c2_g, 1'b1, 5'd7, 1'b0, 1'b1);
        send_block(C_BLK, 1'b1, 5'd16, 1'b1, 1'b0);
        wait_done();
        chk_err(1'b1);

        // Reset mid-multiply abandons the message.
        start_msg();
        send_block(C_BLK, 1'b1, 5'd16, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("midrst_busy[%0d]", k), 128'(busy[k]), 128'd0);
            chk($sformatf("midrst_in_ready[%0d]", k), 128'(in_ready[k]), 128'd0);
        end
        rst = 1'b0;
        repeat (150) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++)
            chk($sformatf("midrst_tag_valid[%0d]", k), 128'(tag_valid[k]), 128'd0);

        // Fresh message after reset; tag must hold while tag_ready is low.
        tag_ready = 3'b000;
        exp_q.push_back(T_C);
        start_msg();
        send_block(C_BLK, 1'b1, 5'd16, 1'b1, 1'b0);
        t = 0;
        while (tag_valid != 3'b111 && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 1000) timeout("tag_valid_wait");
        for (int c = 0; c < 10; c++) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("hold_tag[%0d]", k), tag_o[k], T_C);
                chk($sformatf("hold_tag_valid[%0d]", k), 128'(tag_valid[k]), 128'd1);
            end
            @(posedge clk); #1;
        end
        tag_ready = 3'b111;
        wait_done();
        chk_err(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
